// File: rtl/hello_lcd.sv
// hello_lcd
// Avalon-MM master that initialises an HD44780-style character LCD controller
// and prints a fixed greeting once per reset, then goes idle.
//
// Ports
//   clk          in   1  system clock, all logic on posedge
//   reset        in   1  asynchronous, active-high reset
//   address      out  1  0 = LCD instruction register, 1 = LCD data register
//   chipselect   out  1  mirrors write
//   byteenable   out  1  constant 1
//   read         out  1  constant 0 (reads are never issued)
//   write        out  1  write request, held until accepted
//   waitrequest  in   1  slave stall; accept = write & ~waitrequest
//   readdata     in   8  ignored
//   response     in   2  ignored
//   writedata    out  8  instruction byte or ASCII character
//
// Configuration macro
//   HELLO_LINE2_EN : appends "set DDRAM 0x40" and "MTRX3700" on line 2
//                    (N_INSTRS = 26 instead of 17).
module hello_lcd (
  input  logic       clk,
  input  logic       reset,
  output logic       address,
  output logic       chipselect,
  output logic       byteenable,
  output logic       read,
  output logic       write,
  input  logic       waitrequest,
  input  logic [7:0] readdata,
  input  logic [1:0] response,
  output logic [7:0] writedata
);

`ifdef HELLO_LINE2_EN
  localparam int N_INSTRS = 26;
`else
  localparam int N_INSTRS = 17;
`endif
  localparam int IDX_W = $clog2(N_INSTRS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INSTRS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_index;
  logic [8:0]       w_entry;
  logic             w_unused;

  // ROM entry = {is_char, byte}; is_char drives the LCD register select.
  function automatic logic [8:0] rom_entry(input logic [IDX_W-1:0] idx);
    logic [8:0] v;
    v = {1'b0, 8'h38};
    case (idx)
      5'd0:  v = {1'b0, 8'h38};  // 8-bit bus, 2 lines
      5'd1:  v = {1'b0, 8'h0C};  // display on, cursor off
      5'd2:  v = {1'b0, 8'h01};  // clear
      5'd3:  v = {1'b0, 8'h06};  // entry mode: increment
      5'd4:  v = {1'b0, 8'h80};  // DDRAM address 0
      5'd5:  v = {1'b1, 8'h48};  // H
      5'd6:  v = {1'b1, 8'h65};  // e
      5'd7:  v = {1'b1, 8'h6C};  // l
      5'd8:  v = {1'b1, 8'h6C};  // l
      5'd9:  v = {1'b1, 8'h6F};  // o
      5'd10: v = {1'b1, 8'h20};  // space
      5'd11: v = {1'b1, 8'h57};  // W
      5'd12: v = {1'b1, 8'h6F};  // o
      5'd13: v = {1'b1, 8'h72};  // r
      5'd14: v = {1'b1, 8'h6C};  // l
      5'd15: v = {1'b1, 8'h64};  // d
      5'd16: v = {1'b1, 8'h21};  // !
`ifdef HELLO_LINE2_EN
      5'd17: v = {1'b0, 8'hC0};  // DDRAM address 0x40 (line 2)
      5'd18: v = {1'b1, 8'h4D};  // M
      5'd19: v = {1'b1, 8'h54};  // T
      5'd20: v = {1'b1, 8'h52};  // R
      5'd21: v = {1'b1, 8'h58};  // X
      5'd22: v = {1'b1, 8'h33};  // 3
      5'd23: v = {1'b1, 8'h37};  // 7
      5'd24: v = {1'b1, 8'h30};  // 0
      5'd25: v = {1'b1, 8'h30};  // 0
`endif
      default: v = {1'b0, 8'h38};
    endcase
    return v;
  endfunction

  // Sequencer: walk the ROM one entry per accepted write, stop after the last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_index <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_SEND;
        S_SEND: begin
          if (!waitrequest) begin
            if (r_index == LAST_IDX) begin
              r_state <= S_DONE;
            end else begin
              r_index <= r_index + IDX_W'(1);
            end
          end
        end
        S_DONE: r_state <= S_DONE;
        default: begin
          r_state <= S_IDLE;
          r_index <= '0;
        end
      endcase
    end
  end

  // Bus decode: data/address follow the registered index, so they stay put
  // for as long as the slave stalls.
  always_comb begin
    w_entry    = rom_entry(r_index);
    address    = w_entry[8];
    writedata  = w_entry[7:0];
    write      = (r_state == S_SEND);
    chipselect = write;
    byteenable = 1'b1;
    read       = 1'b0;
  end

  // Inputs required by the bus protocol but not used by a write-only master.
  assign w_unused = ^{readdata, response};

endmodule

// File: tb/tb_hello_lcd.sv
module tb_hello_lcd;

  logic       clk;
  logic       reset;
  logic       address;
  logic       chipselect;
  logic       byteenable;
  logic       read;
  logic       write;
  logic       waitrequest;
  logic [7:0] readdata;
  logic [1:0] response;
  logic [7:0] writedata;

  int errors_r;
  int checks_r;
  int cyc_r;
  int first_wr_cyc_r;
  int n_instrs_r;

  logic [8:0] exp_q[$];
  logic [8:0] acc_q[$];
  int         acc_cyc_q[$];

  logic       prev_stall_r;
  logic [8:0] prev_bus_r;

  hello_lcd dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .byteenable  (byteenable),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .response    (response),
    .writedata   (writedata)
  );

  // Clock: 10 time-unit period, posedge at 5, 15, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check, reports mismatches.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Bus monitor: fixed outputs, stall stability, accepted-write log.
  always @(negedge clk) begin
    check_val("read_zero", {31'd0, read}, 32'd0);
    check_val("byteenable_one", {31'd0, byteenable}, 32'd1);
    check_val("cs_eq_write", {31'd0, chipselect}, {31'd0, write});
    if (reset) begin
      prev_stall_r = 1'b0;
    end else begin
      cyc_r++;
      if (prev_stall_r) begin
        check_val("stall_write", {31'd0, write}, 32'd1);
        check_val("stall_bus", {23'd0, address, writedata}, {23'd0, prev_bus_r});
      end
      if (write && first_wr_cyc_r < 0) first_wr_cyc_r = cyc_r;
      if (write && !waitrequest) begin
        acc_q.push_back({address, writedata});
        acc_cyc_q.push_back(cyc_r);
      end
      prev_stall_r = write && waitrequest;
      prev_bus_r   = {address, writedata};
    end
  end

  // Hold reset for five cycles, check reset values, then release.
  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    waitrequest = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_val("rst_write", {31'd0, write}, 32'd0);
    check_val("rst_addr", {31'd0, address}, 32'd0);
    check_val("rst_data", {24'd0, writedata}, 32'h38);
    acc_q.delete();
    acc_cyc_q.delete();
    cyc_r = 0;
    first_wr_cyc_r = -1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Drive waitrequest until all entries are accepted (mode 0: never stall,
  // mode 1: random 37.5% stalls, capped at n_instrs_r in total).
  task automatic run_seq(input int mode, input int budget);
    int stalls_left;
    int cycles;
    stalls_left = n_instrs_r;
    cycles = 0;
    while (acc_q.size() < n_instrs_r && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      if (mode == 1 && stalls_left > 0 && $urandom_range(7, 0) < 3) begin
        waitrequest = 1'b1;
        stalls_left--;
      end else begin
        waitrequest = 1'b0;
      end
    end
    waitrequest = 1'b0;
    if (acc_q.size() < n_instrs_r) check_val("timeout", acc_q.size(), n_instrs_r);
    repeat (3) @(negedge clk);
    check_val("idle_after_done", {31'd0, write}, 32'd0);
  endtask

  // Compare the accepted-write log with the reference list.
  task automatic check_seq(input string tag);
    check_val({tag, "_count"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      check_val($sformatf("%s_entry%0d", tag, i), {23'd0, acc_q[i]}, {23'd0, exp_q[i]});
    end
  endtask

  // Wait until the given number of writes has been accepted (bounded).
  task automatic wait_accepts(input int n, input string tag);
    int cycles;
    cycles = 0;
    while (acc_q.size() < n && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (acc_q.size() < n) check_val({tag, "_wait"}, acc_q.size(), n);
  endtask

  initial begin
    string greet;
    string line2;
    errors_r = 0;
    checks_r = 0;
    cyc_r = 0;
    first_wr_cyc_r = -1;
    prev_stall_r = 1'b0;
    prev_bus_r = 9'd0;
    reset = 1'b1;
    waitrequest = 1'b0;
    readdata = 8'hA5;
    response = 2'b11;

    // Reference list straight from the greeting text.
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h80});
    greet = "Hello World!";
    for (int i = 0; i < greet.len(); i++) exp_q.push_back({1'b1, greet[i]});
`ifdef HELLO_LINE2_EN
    exp_q.push_back({1'b0, 8'hC0});
    line2 = "MTRX3700";
    for (int i = 0; i < line2.len(); i++) exp_q.push_back({1'b1, line2[i]});
`else
    line2 = "";
`endif
    n_instrs_r = dut.N_INSTRS;
    check_val("n_instrs", n_instrs_r, exp_q.size());

    // 1. Zero stall: consecutive cycles, in-order list.
    apply_reset();
    run_seq(0, 4 * n_instrs_r);
    check_seq("nostall");
    if (acc_cyc_q.size() == n_instrs_r)
      check_val("nostall_span", acc_cyc_q[n_instrs_r-1] - acc_cyc_q[0] + 1, n_instrs_r);

    // 2. Random stalls: same list, bounded completion.
    apply_reset();
    run_seq(1, 4 * n_instrs_r);
    check_seq("rand");
    if (acc_cyc_q.size() == n_instrs_r)
      check_val("rand_within_2n",
                {31'd0, (acc_cyc_q[n_instrs_r-1] - first_wr_cyc_r + 1) <= 2 * n_instrs_r}, 32'd1);

    // 3. Long stall on entry 2.
    apply_reset();
    wait_accepts(2, "stall20");
    waitrequest = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("stall20_write", {31'd0, write}, 32'd1);
      check_val("stall20_data", {24'd0, writedata}, 32'h01);
      @(posedge clk);
    end
    #1;
    waitrequest = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("stall20_next", {23'd0, address, writedata}, {23'd0, 1'b0, 8'h06});
    run_seq(0, 4 * n_instrs_r);
    check_seq("stall20");

    // 4. Reset pulse while 'o' (entry 9) is presented and stalled.
    apply_reset();
    wait_accepts(9, "rstmid");
    waitrequest = 1'b1;
    @(negedge clk);
    check_val("rstmid_present", {23'd0, address, writedata}, {23'd0, 1'b1, 8'h6F});
    #2;
    reset = 1'b1;
    #1;
    check_val("rstmid_async_write", {31'd0, write}, 32'd0);
    check_val("rstmid_async_data", {24'd0, writedata}, 32'h38);
    apply_reset();
    run_seq(0, 4 * n_instrs_r);
    check_seq("rstmid");

    $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
    $finish;
  end

endmodule
